// File: rtl/tpu_multilane_reduce_if.sv
// Config, input-stream and result bundle for tpu_multilane_reduce.
// The slave modport is the reduction engine; the master modport is whoever drives it.
interface tpu_multilane_reduce_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int LEN_BITS   = 13
);
    logic                          start;
    logic                          abort;
    logic [1:0]                    op_mode;
    logic [LEN_BITS-1:0]           length;
    logic [4:0]                    out_shift;
    logic                          round_en;
    logic [LANES*DATA_WIDTH-1:0]   data_in;
    logic                          data_valid;
    logic                          data_ready;
    logic [OUT_WIDTH-1:0]          result;
    logic [LEN_BITS-1:0]           result_index;
    logic                          result_valid;
    logic                          result_ready;
    logic                          saturated;
    logic                          busy;
    logic                          done;
    logic [31:0]                   cycles_count;
    logic [31:0]                   elements_count;

    modport slave (
        input  start, abort, op_mode, length, out_shift, round_en,
        input  data_in, data_valid, result_ready,
        output data_ready, result, result_index, result_valid, saturated,
        output busy, done, cycles_count, elements_count
    );

    modport master (
        output start, abort, op_mode, length, out_shift, round_en,
        output data_in, data_valid, result_ready,
        input  data_ready, result, result_index, result_valid, saturated,
        input  busy, done, cycles_count, elements_count
    );
endinterface

// File: rtl/tpu_multilane_reduce.sv
// Multi-lane streaming SUM/MAX/MIN/ARGMAX reduction with shift, round and saturate.
// Latency: last beat accepted at edge N -> result_valid from edge N+2.
// Backpressure: data_ready only in ACCUM; result held stable until result_ready.
module tpu_multilane_reduce #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int MAX_LENGTH = 4096,
    parameter int OUT_WIDTH  = 32,
    parameter int LEN_BITS   = $clog2(MAX_LENGTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tpu_multilane_reduce_if.slave  bus
);
    localparam int LOG2L = $clog2(LANES);
    localparam int CW    = ACC_WIDTH + LOG2L;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_ARG = 2'b11;

    localparam logic signed [ACC_WIDTH-1:0] ID_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ID_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [CW:0] OUT_MAX =
        {{(CW+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW:0] OUT_MIN =
        {{(CW+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [CW:0] ONE = {{CW{1'b0}}, 1'b1};
    localparam logic [LEN_BITS-1:0] MAX_LEN_V = LEN_BITS'(MAX_LENGTH);
    localparam logic [LEN_BITS:0]   LANES_M1  = (LEN_BITS+1)'(LANES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_COMBINE, S_FINAL, S_OUT} state_t;

    function automatic logic signed [ACC_WIDTH-1:0] ident(input logic [1:0] op);
        case (op)
            OP_SUM:  ident = '0;
            OP_MIN:  ident = ID_MIN;
            default: ident = ID_MAX;
        endcase
    endfunction

    state_t                        state_q;
    logic [1:0]                    op_q;
    logic [LEN_BITS-1:0]           len_q;
    logic [4:0]                    shift_q;
    logic                          round_q;
    logic [LEN_BITS-1:0]           beat_q;
    logic signed [ACC_WIDTH-1:0]   acc_q [LANES];
    logic [LEN_BITS-1:0]           idx_q [LANES];
    logic [LANES-1:0]              has_q;
    logic signed [CW-1:0]          comb_val_q;
    logic [LEN_BITS-1:0]           comb_idx_q;
    logic [OUT_WIDTH-1:0]          result_q;
    logic [LEN_BITS-1:0]           result_index_q;
    logic                          saturated_q;
    logic                          result_valid_q;
    logic                          done_q;
    logic                          busy_q;
    logic                          data_ready_q;
    logic [31:0]                   cycles_q;
    logic [31:0]                   elems_q;

    assign bus.data_ready     = data_ready_q;
    assign bus.result         = result_q;
    assign bus.result_index   = result_index_q;
    assign bus.saturated      = saturated_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.done           = done_q;
    assign bus.busy           = busy_q;
    assign bus.cycles_count   = cycles_q;
    assign bus.elements_count = elems_q;

    // Beat bookkeeping: only the final beat can be partial.
    logic [LEN_BITS:0]  beats_total;
    logic [LEN_BITS:0]  rem_full;
    logic               last_beat;
    logic               accept;
    logic [LANES-1:0]   lane_vld;
    logic [31:0]        pop;

    always_comb begin
        beats_total = ({1'b0, len_q} + LANES_M1) >> LOG2L;
        rem_full    = {1'b0, len_q} - ({1'b0, beat_q} << LOG2L);
        last_beat   = ({1'b0, beat_q} == (beats_total - 1'b1));
        accept      = (state_q == S_ACCUM) && bus.data_valid && data_ready_q;
        lane_vld    = '0;
        pop         = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_vld[i] = !last_beat || ((LEN_BITS+1)'(i) < rem_full);
            pop         = pop + 32'(lane_vld[i]);
        end
    end

    logic signed [ACC_WIDTH-1:0] acc_d [LANES];
    logic [LEN_BITS-1:0]         idx_d [LANES];
    logic [LANES-1:0]            has_d;

    always_comb begin
        has_d = has_q;
        for (int i = 0; i < LANES; i++) begin
            logic signed [DATA_WIDTH-1:0] ld;
            logic signed [ACC_WIDTH-1:0]  ext;
            ld       = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            ext      = lane_vld[i] ? ACC_WIDTH'(ld) : ident(op_q);
            acc_d[i] = acc_q[i];
            idx_d[i] = idx_q[i];
            case (op_q)
                OP_SUM: acc_d[i] = acc_q[i] + ext;
                OP_MAX: if (ext > acc_q[i]) acc_d[i] = ext;
                OP_MIN: if (ext < acc_q[i]) acc_d[i] = ext;
                default: begin
                    // strict > keeps the earliest beat on equal values within a lane
                    if (lane_vld[i] && (!has_q[i] || ext > acc_q[i])) begin
                        acc_d[i] = ext;
                        idx_d[i] = (beat_q << LOG2L) + LEN_BITS'(i);
                        has_d[i] = 1'b1;
                    end
                end
            endcase
        end
    end

    logic signed [CW-1:0]  comb_val_d;
    logic [LEN_BITS-1:0]   comb_idx_d;

    always_comb begin
        logic signed [CW-1:0] v;
        logic                 found;
        comb_val_d = '0;
        comb_idx_d = '0;
        found      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            v = CW'(acc_q[i]);
            case (op_q)
                OP_SUM: comb_val_d = comb_val_d + v;
                OP_MAX: if (i == 0 || v > comb_val_d) comb_val_d = v;
                OP_MIN: if (i == 0 || v < comb_val_d) comb_val_d = v;
                default: begin
                    // lane order is not element order, so ties compare indices explicitly
                    if (has_q[i] && (!found || v > comb_val_d ||
                        (v == comb_val_d && idx_q[i] < comb_idx_d))) begin
                        comb_val_d = v;
                        comb_idx_d = idx_q[i];
                        found      = 1'b1;
                    end
                end
            endcase
        end
    end

    logic [OUT_WIDTH-1:0]  fin_res_d;
    logic [LEN_BITS-1:0]   fin_idx_d;
    logic                  fin_sat_d;

    always_comb begin
        logic signed [CW:0] rnd_v;
        logic signed [CW:0] shf_v;
        rnd_v     = (CW+1)'(comb_val_q);
        if (round_q && shift_q != 5'd0)
            rnd_v = rnd_v + (ONE << (shift_q - 5'd1));
        shf_v     = rnd_v >>> shift_q;
        fin_res_d = '0;
        fin_idx_d = '0;
        fin_sat_d = 1'b0;
        if (len_q != '0) begin
            if (op_q == OP_SUM) begin
                if (shf_v > OUT_MAX) begin
                    fin_res_d = OUT_MAX[OUT_WIDTH-1:0];
                    fin_sat_d = 1'b1;
                end else if (shf_v < OUT_MIN) begin
                    fin_res_d = OUT_MIN[OUT_WIDTH-1:0];
                    fin_sat_d = 1'b1;
                end else begin
                    fin_res_d = shf_v[OUT_WIDTH-1:0];
                end
            end else begin
                fin_res_d = comb_val_q[OUT_WIDTH-1:0];
                if (op_q == OP_ARG) fin_idx_d = comb_idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            len_q          <= '0;
            shift_q        <= '0;
            round_q        <= 1'b0;
            beat_q         <= '0;
            has_q          <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
                idx_q[i] <= '0;
            end
            comb_val_q     <= '0;
            comb_idx_q     <= '0;
            result_q       <= '0;
            result_index_q <= '0;
            saturated_q    <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            data_ready_q   <= 1'b0;
            cycles_q       <= '0;
            elems_q        <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) cycles_q <= cycles_q + 32'd1;
            if (state_q != S_IDLE && bus.abort) begin
                state_q        <= S_IDLE;
                result_valid_q <= 1'b0;
                busy_q         <= 1'b0;
                data_ready_q   <= 1'b0;
                result_q       <= '0;
                result_index_q <= '0;
                saturated_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            op_q     <= bus.op_mode;
                            len_q    <= (bus.length > MAX_LEN_V) ? MAX_LEN_V : bus.length;
                            shift_q  <= bus.out_shift;
                            round_q  <= bus.round_en;
                            beat_q   <= '0;
                            has_q    <= '0;
                            for (int i = 0; i < LANES; i++) begin
                                acc_q[i] <= ident(bus.op_mode);
                                idx_q[i] <= '0;
                            end
                            cycles_q <= '0;
                            elems_q  <= '0;
                            busy_q   <= 1'b1;
                            if (bus.length == '0) begin
                                state_q <= S_COMBINE;
                            end else begin
                                state_q      <= S_ACCUM;
                                data_ready_q <= 1'b1;
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (accept) begin
                            for (int i = 0; i < LANES; i++) begin
                                acc_q[i] <= acc_d[i];
                                idx_q[i] <= idx_d[i];
                            end
                            has_q   <= has_d;
                            beat_q  <= beat_q + 1'b1;
                            elems_q <= elems_q + pop;
                            if (last_beat) begin
                                state_q      <= S_COMBINE;
                                data_ready_q <= 1'b0;
                            end
                        end
                    end
                    S_COMBINE: begin
                        comb_val_q <= comb_val_d;
                        comb_idx_q <= comb_idx_d;
                        state_q    <= S_FINAL;
                    end
                    S_FINAL: begin
                        result_q       <= fin_res_d;
                        result_index_q <= fin_idx_d;
                        saturated_q    <= fin_sat_d;
                        result_valid_q <= 1'b1;
                        state_q        <= S_OUT;
                    end
                    S_OUT: begin
                        if (bus.result_ready) begin
                            result_valid_q <= 1'b0;
                            done_q         <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule
